// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the three-port SPI arbiter: the arbiter FSM state
// encoding, the number of requesting ports, the default abort timeout and a
// small helper that turns a one-hot grant into a port index.
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    localparam int NPORTS          = 3;
    localparam int DEFAULT_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Convert a one-hot (or all-zero) grant vector into the owning port index.
    // All-zero maps to port 0; callers only use the result with a valid grant.
    function automatic logic [1:0] onehot_to_idx(input logic [NPORTS-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick3.sv
// ---------------------------------------------------------------------------
// rr_pick3
// Combinational round-robin picker for three requesters. The search starts
// at the port after the previous owner and wraps, so every port is served
// within three grants when all of them keep requesting.
//   req  : request level per port (bit i = port i)
//   last : index of the previous owner (0..2)
//   gnt  : one-hot choice, all-zero when nobody requests
// ---------------------------------------------------------------------------
module rr_pick3
    import spi_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [1:0]        last,
    output logic [NPORTS-1:0] gnt
);

    // Priority order is rotated by the previous owner; an out-of-range
    // last value behaves like last=2 so port 0 is searched first.
    always_comb begin
        gnt = '0;
        case (last)
            2'd0: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
// Shares one SPI master between three ports. A granted port's command is
// latched, issued as a single spi_start pulse, and the arbiter then waits for
// spi_done or aborts the transfer after TIMEOUT wait cycles.
//   clk, rst              : clock, asynchronous active-high reset
//   halt                  : blocks new grants (in-flight work completes)
//   req/req_we/req_rom    : per-port request, write enable, ROM select
//   req_addr/req_wdata    : per-port address (16 b) and write data (8 b)
//   gnt/ack/err           : one-hot owner, completion pulse, timeout pulse
//   rdata                 : data of the most recent completed read
//   busy                  : arbiter not idle
//   spi_start/spi_abort   : command and abort pulses to the SPI master
//   spi_we/rom/addr/wdata : latched command fields for the SPI master
//   spi_done/spi_rdata    : completion pulse and read data from the master
// ---------------------------------------------------------------------------
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    req_we,
    input  logic [NPORTS-1:0]    req_rom,
    input  logic [16*NPORTS-1:0] req_addr,
    input  logic [8*NPORTS-1:0]  req_wdata,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    ack,
    output logic [NPORTS-1:0]    err,
    output logic [7:0]           rdata,
    output logic                 busy,
    output logic                 spi_start,
    output logic                 spi_we,
    output logic                 spi_rom,
    output logic [15:0]          spi_addr,
    output logic [7:0]           spi_wdata,
    input  logic                 spi_done,
    input  logic [7:0]           spi_rdata,
    output logic                 spi_abort
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    logic [15:0]       timer;
    logic [1:0]        last;
    logic [1:0]        idx;
    logic [NPORTS-1:0] pick;
    logic [1:0]        pick_idx;
    logic [5:0]        addr_base;
    logic [4:0]        data_base;

    rr_pick3 u_pick (
        .req  (req),
        .last (last),
        .gnt  (pick)
    );

    assign pick_idx  = onehot_to_idx(pick);
    assign addr_base = {pick_idx, 4'b0000};
    assign data_base = {pick_idx, 3'b000};

    assign busy = (state != IDLE);

    // The abort must appear in the same WAIT cycle that reaches the limit,
    // and a simultaneous spi_done suppresses it, so it is decoded from the
    // current state and input rather than registered.
    assign spi_abort = (state == WAIT) && !spi_done && (timer == TIMER_LAST);

    // Arbiter FSM. All bus-facing outputs except spi_abort are registered
    // here so they change exactly on state transitions: the grant and latched
    // command appear on entry to ISSUE, ack/err are set on entry to RESP and
    // everything owner-related is dropped on the way back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            last      <= 2'd2;
            idx       <= 2'd0;
            gnt       <= '0;
            ack       <= '0;
            err       <= '0;
            rdata     <= '0;
            spi_start <= 1'b0;
            spi_we    <= 1'b0;
            spi_rom   <= 1'b0;
            spi_addr  <= '0;
            spi_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt && (req != '0)) begin
                        gnt       <= pick;
                        idx       <= pick_idx;
                        spi_we    <= req_we[pick_idx];
                        spi_rom   <= req_rom[pick_idx];
                        spi_addr  <= req_addr[addr_base +: 16];
                        spi_wdata <= req_wdata[data_base +: 8];
                        spi_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    spi_start <= 1'b0;
                    timer     <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        ack <= gnt;
                        if (!spi_we) rdata <= spi_rdata;
                        state <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        err   <= gnt;
                        state <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    ack   <= '0;
                    err   <= '0;
                    gnt   <= '0;
                    last  <= idx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum WAIT cycles before abort; legal range 2..65535.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 halt  in  1  blocks new grants; an in-flight transaction still completes.
REQ-005 req  in  3  per-port request level; port i owns bit i; held until ack/err.
REQ-006 req_we  in  3  per-port write enable; 1=write, 0=read.
REQ-007 req_rom  in  3  per-port device select; 1=ROM chip, 0=RAM chip.
REQ-008 req_addr  in  48  per-port address; port i uses bits [16i+15:16i].
REQ-009 req_wdata  in  24  per-port write data; port i uses bits [8i+7:8i].
REQ-010 gnt  out  3  one-hot owner of the bus; all-zero when idle.
REQ-011 ack  out  3  one-cycle completion pulse to the owning port.
REQ-012 err  out  3  one-cycle timeout pulse to the owning port.
REQ-013 rdata  out  8  data from the most recent completed read.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 spi_start  out  1  one-cycle command pulse to the SPI master.
REQ-016 spi_we  out  1  latched write enable; valid from spi_start until ack/err.
REQ-017 spi_rom  out  1  latched device select; same validity as spi_we.
REQ-018 spi_addr  out  16  latched address; same validity as spi_we.
REQ-019 spi_wdata  out  8  latched write data; same validity as spi_we.
REQ-020 spi_done  in  1  one-cycle completion pulse from the SPI master.
REQ-021 spi_rdata  in  8  read data; valid in the spi_done cycle.
REQ-022 spi_abort  out  1  one-cycle pulse telling the SPI master to drop its transfer.

Function
REQ-023 FSM states are IDLE, ISSUE, WAIT and RESP; no other state is reachable.
REQ-024 IDLE: when halt=0 and req!=0, grant by round-robin starting at (last+1) mod 3, latch the port's we/rom/addr/wdata and go to ISSUE; otherwise stay in IDLE.
REQ-025 ISSUE: spi_start=1 for exactly this cycle, gnt held, timer cleared, go to WAIT; request-to-spi_start latency is exactly 1 cycle.
REQ-026 WAIT: spi_done=1 goes to RESP with ok status; a read copies spi_rdata into rdata; a write leaves rdata unchanged.
REQ-027 WAIT: with spi_done=0, the timer increments; when timer==TIMEOUT-1, spi_abort=1 for this cycle and go to RESP with error status.
REQ-028 When spi_done and the timeout coincide, spi_done wins: ack, no abort.
REQ-029 RESP: ack[idx] or err[idx] is 1 for exactly this cycle, last<=idx, go to IDLE; spi_done-to-ack latency is exactly 1 cycle.
REQ-030 gnt[idx]=1 from ISSUE through RESP inclusive, and 0 in IDLE.
REQ-031 spi_done outside WAIT is ignored.
REQ-032 Changes on a granted port's req/addr/data after the grant are ignored; the latched transaction completes and ack/err still pulses.
REQ-033 A requester drops req in the cycle after ack/err; a req still high in IDLE is a new request.
REQ-034 halt is sampled only in IDLE; WAIT ignores halt.

Reset
REQ-035 On rst: state=IDLE, timer=0, last=2 so that port 0 has first priority, all latches=0, and all outputs=0 including rdata.
REQ-036 rst mid-transaction discards the transaction with no ack, err or abort pulse; the SPI master is reset by the same rst.

Structure
REQ-037 Package spi_arb_pkg holds the state enum, NPORTS=3, and the default TIMEOUT value.
REQ-038 The combinational round-robin picker is a sub-module named rr_pick3, with inputs req[2:0] and last[1:0] and output one-hot gnt[2:0].

Verification
REQ-039 Port1 read, rom=1, addr=0x1234; spi_done with rdata 0xA5 three cycles after spi_start -> spi_start 1 cycle after req, spi_addr=0x1234, ack[1] 1 cycle after spi_done, rdata=0xA5.
REQ-040 Right after reset, req=3'b111 held with immediate spi_done -> grant order 0,1,2,0.
REQ-041 Port2 write with no spi_done, TIMEOUT=8 -> spi_abort and err[2] after 8 WAIT cycles, no ack, rdata unchanged.
REQ-042 halt raised in WAIT -> ack still occurs; no grant while halt=1; grant in the first IDLE cycle after halt falls.
REQ-043 rst pulsed in WAIT -> all outputs 0; a subsequent port2 request is granted with normal latency.
REQ-044 spi_done exactly at timer==TIMEOUT-1 -> ack[idx]=1, err=0, spi_abort=0.
